rst_sequencer: RTL and testbench
================================

// Module: rst_sequencer
// PURPOSE
//  Reset controller sitting directly upstream of the design's flip-flops. Async-asserts,
//  sync-deasserts a raw active-low reset, stretches it, then releases N downstream reset
//  domains in fixed order. Also drives an active-high synchronous reset and accepts a
//  software reset request.
// PARAMETERS
//  SYNC_STAGES     2   synchronizer flop depth for async_rst_n deassertion (>=2)
//  STRETCH_CYCLES  8   edges reset is held after sync release or sw request (>=1)
//  N_STAGES        3   number of sequenced reset domains (1..8)
//  STAGE_GAP       4   edges between successive stage releases (>=1)
// PORTS
//  clk          in   1         system clock, rising edge
//  async_rst_n  in   1         asynchronous active-low reset, raw (unsynchronized) source
//  sw_rst_req   in   1         synchronous sw reset request, sampled on clk rise
//  stage_rst_n  out  N_STAGES  per-domain active-low reset (async assert, sync release)
//  sync_rst     out  1         active-high synchronous reset for sync-reset flops
//  rst_done     out  1         1 = all domains out of reset
//  rst_cause    out  2         sticky: 2'b01 = async_rst_n, 2'b10 = sw_rst_req
// BEHAVIOUR
//  Reset: one clock (clk). Reset is async_rst_n: asynchronous, active-low.
//  async_rst_n=0: immediately (no clk) stage_rst_n=0, sync_rst=1, rst_done=0,
//   rst_cause=2'b01, synchronizer cleared, FSM=HOLD, counters=0.
//  FSM: HOLD -> SYNC -> STRETCH -> RELEASE -> RUN.
//   HOLD: while async_rst_n=0.
//   SYNC: sync chain shifts in 1s. Synchronized reset goes high after edge SYNC_STAGES.
//    Edge 1 = first clk rise sampling async_rst_n=1. Enter STRETCH on that edge.
//   STRETCH: count STRETCH_CYCLES edges. On final edge, stage_rst_n[0]=1 and enter RELEASE.
//    Absolute edge of stage_rst_n[0] release = SYNC_STAGES+STRETCH_CYCLES.
//   RELEASE: stage_rst_n[k] rises exactly STAGE_GAP edges after stage_rst_n[k-1].
//    Release order is fixed: once a bit is 1, lower bits stay 1.
//    sync_rst falls on the same edge as stage_rst_n[N_STAGES-1]. Then enter RUN.
//   RUN: rst_done rises one edge after the last stage release, and stays 1.
//  Defaults: stage0 release at edge 10, stage1 at 14, stage2 at 18; sync_rst falls at 18;
//   rst_done rises at 19.
//  sw_rst_req=1 sampled in STRETCH, RELEASE or RUN, at edge E:
//   - after E: all stage_rst_n=0, sync_rst=1, rst_done=0, rst_cause=2'b10.
//   - STRETCH counter reloads, FSM=STRETCH. Synchronizer is not re-run.
//   - stage_rst_n[0] releases at edge E+STRETCH_CYCLES.
//  sw_rst_req held high: reload on every edge; release counts from the last edge it was high.
//  sw_rst_req is ignored in HOLD and SYNC. rst_cause remains 2'b01.
//  async_rst_n low in any state (mid-STRETCH, mid-RELEASE, RUN) aborts immediately,
//   returns to HOLD, and on deassertion runs the full sequence again.
//  async_rst_n pulse shorter than a clk period still fully resets, since assertion is async.
//  Simultaneous async_rst_n=0 and sw_rst_req=1: async wins, rst_cause=2'b01.
//  Counters are sized $clog2(max(STRETCH_CYCLES,STAGE_GAP)+1) and must not wrap.
// TESTING
//  1 Power-up, defaults, async_rst_n 0->1 between edges: stage_rst_n releases at edges
//    10/14/18 as 001/011/111; sync_rst 1->0 at edge 18; rst_done=1 at 19; rst_cause=01.
//  2 In RUN, 1-cycle sw_rst_req at edge E: after E stage_rst_n=000, sync_rst=1, rst_done=0,
//    rst_cause=10; stage0 releases at E+8, stage2 at E+16.
//  3 Mid-RELEASE (stage_rst_n=011), async_rst_n=0 for 2ns between edges: outputs 000,
//    sync_rst=1 with no clk edge; full sequence restarts, stage0 at 10 edges after deassert.
//  4 sw_rst_req held high for 5 edges during STRETCH: stage0 releases 8 edges after the
//    last edge sampling it high.
//  5 sw_rst_req=1 during SYNC, and sw_rst_req=1 together with async_rst_n=0: both ignored;
//    timing matches test 1; rst_cause=01.
//  6 Sweep SYNC_STAGES=3, STRETCH_CYCLES=1, N_STAGES=1, STAGE_GAP=1: stage0 and sync_rst
//    change at edge 4; rst_done=1 at edge 5.

Source files
------------

// File: rtl/rst_sequencer.sv
// rst_sequencer: reset controller for the downstream flip-flops.
//   Asynchronously asserts and synchronously deasserts a raw active-low reset.
//   Holds reset for a stretch period, then releases N reset domains one after
//   another in a fixed order. It also drives an active-high synchronous reset
//   and accepts a software reset request.
// Ports:
//   clk          in   system clock, rising edge
//   async_rst_n  in   raw asynchronous active-low reset
//   sw_rst_req   in   synchronous software reset request
//   stage_rst_n  out  per-domain active-low resets (async assert, sync release)
//   sync_rst     out  active-high synchronous reset, falls with the last domain
//   rst_done     out  1 once every domain is out of reset
//   rst_cause    out  sticky cause: 2'b01 async reset, 2'b10 software request
module rst_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 8,
  parameter int N_STAGES       = 3,
  parameter int STAGE_GAP      = 4
) (
  input  logic                clk,
  input  logic                async_rst_n,
  input  logic                sw_rst_req,
  output logic [N_STAGES-1:0] stage_rst_n,
  output logic                sync_rst,
  output logic                rst_done,
  output logic [1:0]          rst_cause
);

  localparam int MAX_CNT = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);

  typedef enum logic [2:0] {HOLD, SYNC, STRETCH, RELEASE, RUN} state_t;

  state_t               state, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]        cnt, cnt_d;
  logic [N_STAGES-1:0]  stage_d, stage_next;
  logic                 sync_rst_d, rst_done_d;
  logic [1:0]           cause_d;
  logic                 sync_done;

  // The synchronized reset goes high on this edge: leave SYNC on the same edge.
  assign sync_done  = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
  // Next release pattern: shift one more 1 in from the bottom.
  assign stage_next = (stage_rst_n << 1) | N_STAGES'(1);

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state       <= HOLD;
      sync_q      <= '0;
      cnt         <= '0;
      stage_rst_n <= '0;
      sync_rst    <= 1'b1;
      rst_done    <= 1'b0;
      rst_cause   <= 2'b01;
    end else begin
      state       <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      cnt         <= cnt_d;
      stage_rst_n <= stage_d;
      sync_rst    <= sync_rst_d;
      rst_done    <= rst_done_d;
      rst_cause   <= cause_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    stage_d    = stage_rst_n;
    sync_rst_d = sync_rst;
    rst_done_d = rst_done;
    cause_d    = rst_cause;
    case (state)
      HOLD, SYNC: begin
        if (sync_done) begin
          state_d = STRETCH;
          cnt_d   = '0;
        end else begin
          state_d = SYNC;
        end
      end
      STRETCH, RELEASE, RUN: begin
        if (sw_rst_req) begin
          state_d    = STRETCH;
          cnt_d      = '0;
          stage_d    = '0;
          sync_rst_d = 1'b1;
          rst_done_d = 1'b0;
          cause_d    = 2'b10;
        end else if (state == RUN) begin
          rst_done_d = 1'b1;
        end else if ((state == STRETCH && cnt == STRETCH_LAST) ||
                     (state == RELEASE && cnt == GAP_LAST)) begin
          // The stretch end releases domain 0; each gap end releases the next one.
          stage_d = stage_next;
          cnt_d   = '0;
          if (stage_next[N_STAGES-1]) begin
            sync_rst_d = 1'b0;
            state_d    = RUN;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = HOLD;
    endcase
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: self-checking bench for rst_sequencer.
//   Instance 0 uses the default parameters; instance 1 uses the
//   SYNC_STAGES=3 / STRETCH_CYCLES=1 / N_STAGES=1 / STAGE_GAP=1 sweep.
//   The reference model counts edges since the stretch period started and
//   derives every output arithmetically from that count.
module tb_rst_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n  = 1'b1;
  logic       rst6_n = 1'b1;
  logic       sw     = 1'b0;
  logic       sw6    = 1'b0;
  logic [2:0] stage;
  logic       sync_rst, done;
  logic [1:0] cause;
  logic [0:0] stage6;
  logic       sync6, done6;
  logic [1:0] cause6;

  rst_sequencer #(.SYNC_STAGES(2), .STRETCH_CYCLES(8), .N_STAGES(3), .STAGE_GAP(4)) dut (
    .clk(clk), .async_rst_n(rst_n), .sw_rst_req(sw),
    .stage_rst_n(stage), .sync_rst(sync_rst), .rst_done(done), .rst_cause(cause)
  );

  rst_sequencer #(.SYNC_STAGES(3), .STRETCH_CYCLES(1), .N_STAGES(1), .STAGE_GAP(1)) dut6 (
    .clk(clk), .async_rst_n(rst6_n), .sw_rst_req(sw6),
    .stage_rst_n(stage6), .sync_rst(sync6), .rst_done(done6), .rst_cause(cause6)
  );

  int vectors     = 0;
  int miscompares = 0;

  int p_ss[2] = '{2, 3};
  int p_sc[2] = '{8, 1};
  int p_n[2]  = '{3, 1};
  int p_g[2]  = '{4, 1};

  // Model state: edges since deassertion, edges since stretch start (-1 = not started).
  bit inrst[2];
  int n_edge[2];
  int rel[2];
  int cause_m[2];

  task automatic model_reset(input int i);
    inrst[i]   = 1'b1;
    n_edge[i]  = 0;
    rel[i]     = -1;
    cause_m[i] = 1;
  endtask

  task automatic model_release(input int i);
    inrst[i] = 1'b0;
  endtask

  task automatic model_edge(input int i, input logic swv);
    if (inrst[i]) return;
    n_edge[i]++;
    if (swv && n_edge[i] > p_ss[i]) begin
      rel[i]     = 0;
      cause_m[i] = 2;
    end else if (n_edge[i] == p_ss[i]) begin
      rel[i] = 0;
    end else if (rel[i] >= 0 && rel[i] < 1000) begin
      rel[i]++;
    end
  endtask

  task automatic check(input int i);
    int         k;
    logic [2:0] es, as;
    logic       esr, asr, ed, ad;
    logic [1:0] ec, ac;
    if (rel[i] < p_sc[i]) k = 0;
    else begin
      k = (rel[i] - p_sc[i]) / p_g[i] + 1;
      if (k > p_n[i]) k = p_n[i];
    end
    es  = 3'((1 << k) - 1);
    esr = (k < p_n[i]);
    ed  = (rel[i] >= p_sc[i] + (p_n[i] - 1) * p_g[i] + 1);
    ec  = 2'(cause_m[i]);
    if (i == 0) begin
      as = stage; asr = sync_rst; ad = done; ac = cause;
    end else begin
      as = {2'b00, stage6}; asr = sync6; ad = done6; ac = cause6;
    end
    vectors++;
    assert (as === es) else begin
      miscompares++;
      $error("FAIL stage_rst_n inst%0d t=%0t got %b want %b", i, $time, as, es);
    end
    vectors++;
    assert (asr === esr) else begin
      miscompares++;
      $error("FAIL sync_rst inst%0d t=%0t got %b want %b", i, $time, asr, esr);
    end
    vectors++;
    assert (ad === ed) else begin
      miscompares++;
      $error("FAIL rst_done inst%0d t=%0t got %b want %b", i, $time, ad, ed);
    end
    vectors++;
    assert (ac === ec) else begin
      miscompares++;
      $error("FAIL rst_cause inst%0d t=%0t got %b want %b", i, $time, ac, ec);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0, sw);
    model_edge(1, sw6);
    #1;
    check(0);
    check(1);
  endtask

  // 2 ns reset pulse between edges; called 1 ns after a rising edge.
  task automatic abort(input int i);
    #3;
    if (i == 0) rst_n = 1'b0; else rst6_n = 1'b0;
    model_reset(i);
    #1;
    check(i);
    #1;
    if (i == 0) rst_n = 1'b1; else rst6_n = 1'b1;
    model_release(i);
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    #1;
    rst_n  = 1'b0;
    rst6_n = 1'b0;
    #1;
    check(0);
    check(1);
    tick();
    tick();
    // power-up release between edges, default and sweep instances
    rst_n  = 1'b1;
    rst6_n = 1'b1;
    model_release(0);
    model_release(1);
    repeat (22) tick();

    // one-cycle software request in RUN
    sw = 1'b1; tick(); sw = 1'b0;
    repeat (20) tick();

    // software request at a random point in STRETCH/RELEASE
    sw = 1'b1; tick(); sw = 1'b0;
    repeat ($urandom_range(9, 16)) tick();
    sw = 1'b1; tick(); sw = 1'b0;
    repeat (20) tick();

    // request held high for 5 edges during STRETCH
    sw = 1'b1; tick(); sw = 1'b0;
    repeat (2) tick();
    sw = 1'b1; repeat (5) tick(); sw = 1'b0;
    repeat (20) tick();

    // async abort mid-RELEASE (stage_rst_n = 011) and full restart
    abort(0);
    repeat (14) tick();
    abort(0);
    repeat (22) tick();

    // request during reset and during SYNC is ignored
    #3;
    rst_n = 1'b0;
    sw    = 1'b1;
    model_reset(0);
    #1;
    check(0);
    tick();
    tick();
    rst_n = 1'b1;
    model_release(0);
    tick();
    tick();
    sw = 1'b0;
    repeat (20) tick();

    // randomized requests and aborts on both instances
    repeat (150) begin
      sw  = ($urandom_range(0, 11) == 0);
      sw6 = ($urandom_range(0, 5) == 0);
      tick();
      if ($urandom_range(0, 39) == 0) abort(0);
      else if ($urandom_range(0, 29) == 0) abort(1);
    end
    sw  = 1'b0;
    sw6 = 1'b0;
    repeat (25) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
